// File: rtl/priority_index_fifo.sv
// priority_index_fifo
//
// Converts the one-hot highest/lowest set-bit vectors from an upstream
// priority encoder into binary indices and the span between them.
// Each result is queued in a small first-word-fall-through FIFO.
// Upstream is never back-pressured: an input that arrives while the FIFO is
// full (with no pop on the same edge) is dropped, and a sticky overflow
// flag is raised.
//
// Ports
//   clk_i        : clock, all state changes on the rising edge
//   arst_i       : asynchronous active-high reset
//   data_left_i  : one-hot (or zero) highest-set-bit vector
//   data_right_i : one-hot (or zero) lowest-set-bit vector
//   data_val_i   : input valid (no backpressure)
//   idx_left_o   : head entry left index (0 when valid_o=0)
//   idx_right_o  : head entry right index (0 when valid_o=0)
//   span_o       : head entry idx_left - idx_right, modulo 2^IDX_W
//   zero_o       : head entry came from an all-zero data_left_i
//   valid_o      : head entry present
//   ready_i      : downstream accepts the head entry when valid_o & ready_i
//   count_o      : current occupancy, 0..DEPTH
//   overflow_o   : sticky, an input was dropped because the FIFO was full
module priority_index_fifo #(
  parameter int  WIDTH = 16,
  parameter int  DEPTH = 4,
  localparam int IDX_W = $clog2(WIDTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [WIDTH-1:0] data_left_i,
  input  logic [WIDTH-1:0] data_right_i,
  input  logic             data_val_i,
  output logic [IDX_W-1:0] idx_left_o,
  output logic [IDX_W-1:0] idx_right_o,
  output logic [IDX_W-1:0] span_o,
  output logic             zero_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam int              ENTRY_W  = 3 * IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Per-bit position contributions; the OR of all of them is the index.
  // Exact for one-hot input, 0 for all-zero input.
  logic [IDX_W-1:0] left_pos  [WIDTH];
  logic [IDX_W-1:0] right_pos [WIDTH];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pos
      assign left_pos[gi]  = data_left_i[gi]  ? IDX_W'(gi) : '0;
      assign right_pos[gi] = data_right_i[gi] ? IDX_W'(gi) : '0;
    end
  endgenerate

  logic [IDX_W-1:0] left_idx;
  logic [IDX_W-1:0] right_idx;

  always_comb begin
    left_idx  = '0;
    right_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      left_idx  = left_idx  | left_pos[i];
      right_idx = right_idx | right_pos[i];
    end
  end

  // An all-zero left vector marks the entry as "zero"; its indices and span
  // are stored as 0 regardless of what the right vector holds.
  logic             in_zero;
  logic [ENTRY_W-1:0] entry_in;

  always_comb begin
    in_zero  = (data_left_i == '0);
    entry_in = '0;
    if (in_zero) begin
      entry_in = {1'b1, {(3 * IDX_W){1'b0}}};
    end else begin
      entry_in = {1'b0, IDX_W'(left_idx - right_idx), right_idx, left_idx};
    end
  end

  // Storage is left unreset; it is never visible while the FIFO is empty.
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             overflow_reg, overflow_next;

  logic full;
  logic pop;
  logic push;

  always_comb begin
    full          = (count_reg == FULL_CNT);
    pop           = (count_reg != '0) && ready_i;
    // A pop on the same edge frees a slot, so a full FIFO still accepts.
    push          = data_val_i && (!full || pop);
    wr_ptr_next   = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    rd_ptr_next   = pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    count_next    = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    overflow_next = overflow_reg || (data_val_i && !push);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_reg] <= entry_in;
    end
  end

  // Head entry is read combinationally for fall-through and masked to 0
  // whenever the FIFO is empty.
  logic [ENTRY_W-1:0] head;

  always_comb begin
    head        = valid_o ? mem[rd_ptr_reg] : '0;
    idx_left_o  = head[IDX_W-1:0];
    idx_right_o = head[2*IDX_W-1:IDX_W];
    span_o      = head[3*IDX_W-1:2*IDX_W];
    zero_o      = head[ENTRY_W-1];
  end

  assign valid_o    = (count_reg != '0);
  assign count_o    = count_reg;
  assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_priority_index_fifo.sv
module tb_priority_index_fifo;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic [15:0] data_left_i;
  logic [15:0] data_right_i;
  logic        data_val_i;
  logic [3:0]  idx_left_o;
  logic [3:0]  idx_right_o;
  logic [3:0]  span_o;
  logic        zero_o;
  logic        valid_o;
  logic        ready_i;
  logic [2:0]  count_o;
  logic        overflow_o;

  int n_checks = 0;
  int n_errors = 0;

  priority_index_fifo #(.WIDTH(16), .DEPTH(4)) dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .data_left_i  (data_left_i),
    .data_right_i (data_right_i),
    .data_val_i   (data_val_i),
    .idx_left_o   (idx_left_o),
    .idx_right_o  (idx_right_o),
    .span_o       (span_o),
    .zero_o       (zero_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .count_o      (count_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle 1 time unit before sampling.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_only(input logic [15:0] l, input logic [15:0] r);
    data_left_i  = l;
    data_right_i = r;
    data_val_i   = 1'b1;
    ready_i      = 1'b0;
    step();
    data_val_i   = 1'b0;
    $display("push left=%04h right=%04h -> count=%0d valid=%0b ovf=%0b", l, r, count_o, valid_o, overflow_o);
  endtask

  task automatic pop_only();
    data_val_i = 1'b0;
    ready_i    = 1'b1;
    step();
    ready_i    = 1'b0;
    $display("pop -> count=%0d valid=%0b", count_o, valid_o);
  endtask

  task automatic chk_head(input string tag, input logic [3:0] l, input logic [3:0] r,
                          input logic [3:0] s, input logic z);
    chk({tag, "_valid"}, 32'(valid_o), 32'd1);
    chk({tag, "_idx_left"}, 32'(idx_left_o), 32'(l));
    chk({tag, "_idx_right"}, 32'(idx_right_o), 32'(r));
    chk({tag, "_span"}, 32'(span_o), 32'(s));
    chk({tag, "_zero"}, 32'(zero_o), 32'(z));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_count"}, 32'(count_o), 32'd0);
    chk({tag, "_valid"}, 32'(valid_o), 32'd0);
    chk({tag, "_idx_left"}, 32'(idx_left_o), 32'd0);
    chk({tag, "_idx_right"}, 32'(idx_right_o), 32'd0);
    chk({tag, "_span"}, 32'(span_o), 32'd0);
    chk({tag, "_zero"}, 32'(zero_o), 32'd0);
  endtask

  initial begin
    arst_i       = 1'b1;
    data_left_i  = '0;
    data_right_i = '0;
    data_val_i   = 1'b0;
    ready_i      = 1'b0;
    #2;
    chk_empty("reset");
    chk("reset_overflow", 32'(overflow_o), 32'd0);
    #10;
    arst_i = 1'b0;
    step();

    // Basic push: left bit 8, right bit 2 -> span 6.
    push_only(16'h0100, 16'h0004);
    chk_head("push1", 4'd8, 4'd2, 4'd6, 1'b0);
    chk("push1_count", 32'(count_o), 32'd1);
    pop_only();
    chk_empty("pop1");

    // All-zero left vector.
    push_only(16'h0000, 16'h0000);
    chk_head("zero", 4'd0, 4'd0, 4'd0, 1'b1);

    // Push + pop at count=1; malformed entry left=1, right=3 wraps span to 14.
    data_left_i  = 16'h0002;
    data_right_i = 16'h0008;
    data_val_i   = 1'b1;
    ready_i      = 1'b1;
    step();
    data_val_i   = 1'b0;
    ready_i      = 1'b0;
    $display("push+pop at count 1 -> count=%0d", count_o);
    chk("pp1_count", 32'(count_o), 32'd1);
    chk_head("wrap", 4'd1, 4'd3, 4'd14, 1'b0);
    pop_only();
    chk_empty("pop_wrap");

    // Five pushes into a DEPTH=4 FIFO; the fifth is dropped.
    for (int i = 0; i < 5; i++) begin
      push_only(16'(1 << i), 16'(1 << i));
      chk("fill_count", 32'(count_o), (i < 4) ? 32'(i + 1) : 32'd4);
      chk("fill_overflow", 32'(overflow_o), (i < 4) ? 32'd0 : 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      chk_head("drain", 4'(i), 4'(i), 4'd0, 1'b0);
      pop_only();
    end
    chk_empty("drained");
    chk("overflow_sticky", 32'(overflow_o), 32'd1);

    // Reset pulse between edges clears the sticky flag immediately.
    arst_i = 1'b1;
    #1;
    chk("rst1_overflow", 32'(overflow_o), 32'd0);
    arst_i = 1'b0;
    step();

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 4; i++) push_only(16'(1 << (i + 4)), 16'h0001);
    chk("full_count", 32'(count_o), 32'd4);
    data_left_i  = 16'h1000;
    data_right_i = 16'h0001;
    data_val_i   = 1'b1;
    ready_i      = 1'b1;
    step();
    data_val_i   = 1'b0;
    ready_i      = 1'b0;
    $display("push+pop at full -> count=%0d ovf=%0b", count_o, overflow_o);
    chk("fullpp_count", 32'(count_o), 32'd4);
    chk("fullpp_overflow", 32'(overflow_o), 32'd0);
    chk_head("fullpp_h0", 4'd5, 4'd0, 4'd5, 1'b0);
    pop_only();
    chk_head("fullpp_h1", 4'd6, 4'd0, 4'd6, 1'b0);
    pop_only();
    chk_head("fullpp_h2", 4'd7, 4'd0, 4'd7, 1'b0);
    pop_only();
    chk_head("fullpp_h3", 4'd12, 4'd0, 4'd12, 1'b0);
    pop_only();
    chk_empty("fullpp_done");

    // Reset mid-operation with three entries queued; make overflow set first.
    for (int i = 0; i < 5; i++) push_only(16'h0200, 16'h0002);
    pop_only();
    chk("pre_rst_count", 32'(count_o), 32'd3);
    chk("pre_rst_overflow", 32'(overflow_o), 32'd1);
    arst_i = 1'b1;
    #1;
    $display("async reset mid-operation -> count=%0d valid=%0b ovf=%0b", count_o, valid_o, overflow_o);
    chk_empty("midrst");
    chk("midrst_overflow", 32'(overflow_o), 32'd0);
    #1;
    arst_i = 1'b0;
    push_only(16'h8000, 16'h0001);
    chk("postrst_count", 32'(count_o), 32'd1);
    chk_head("postrst", 4'd15, 4'd0, 4'd15, 1'b0);
    pop_only();

    // ready_i held while empty must not underflow.
    for (int i = 0; i < 10; i++) begin
      pop_only();
      chk("idle_ready_count", 32'(count_o), 32'd0);
      chk("idle_ready_valid", 32'(valid_o), 32'd0);
    end
    push_only(16'h0040, 16'h0010);
    chk("after_idle_count", 32'(count_o), 32'd1);
    chk_head("after_idle", 4'd6, 4'd4, 4'd2, 1'b0);
    push_only(16'h0400, 16'h0400);
    chk("after_idle_count2", 32'(count_o), 32'd2);
    chk_head("after_idle_order", 4'd6, 4'd4, 4'd2, 1'b0);
    pop_only();
    chk_head("after_idle_second", 4'd10, 4'd10, 4'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
